// File: rtl/button_debounce.sv
// button_debounce: synchronises and debounces one raw push-button, with optional auto-repeat pulses.
//   clk        : system clock, single domain
//   reset      : synchronous, active-high
//   btn_raw    : raw asynchronous, bouncy, active-high button input
//   btn_level  : registered debounced level
//   btn_repeat : one-cycle auto-repeat pulse while held (only when BUTTON_AUTO_REPEAT_EN is defined)
module button_debounce #(
    parameter int CNT_W           = 20,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 1000000,
    parameter int REPEAT_CYCLES   = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_repeat
);
    if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1)
        $error("button_debounce: cycle parameters must be >= 1");

    localparam logic [CNT_W-1:0] DEB = CNT_W'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {IDLE, WAIT_HIGH, PRESSED, WAIT_LOW} state_t;

    logic             r_sync1, r_sync2;
    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_deb_cnt, w_deb_nxt, w_deb_inc;
    logic             r_level, w_level_nxt;
    logic             w_deb_done;

    // deb_cnt counts stable samples already seen; the current sample makes it w_deb_inc.
    // deb_cnt is always 0 in IDLE/PRESSED, so DEBOUNCE_CYCLES == 1 jumps straight across.
    assign w_deb_inc  = r_deb_cnt + 1'b1;
    assign w_deb_done = (w_deb_inc == DEB);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_state   <= IDLE;
            r_deb_cnt <= '0;
            r_level   <= 1'b0;
        end else begin
            r_sync1   <= btn_raw;
            r_sync2   <= r_sync1;
            r_state   <= w_state_nxt;
            r_deb_cnt <= w_deb_nxt;
            r_level   <= w_level_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_deb_nxt   = r_deb_cnt;
        w_level_nxt = r_level;
        case (r_state)
            IDLE: begin
                if (r_sync2) begin
                    w_state_nxt = w_deb_done ? PRESSED : WAIT_HIGH;
                    w_deb_nxt   = w_deb_done ? '0 : w_deb_inc;
                    w_level_nxt = w_deb_done;
                end
            end
            WAIT_HIGH: begin
                if (!r_sync2) begin
                    w_state_nxt = IDLE;
                    w_deb_nxt   = '0;
                end else if (w_deb_done) begin
                    w_state_nxt = PRESSED;
                    w_deb_nxt   = '0;
                    w_level_nxt = 1'b1;
                end else begin
                    w_deb_nxt   = w_deb_inc;
                end
            end
            PRESSED: begin
                if (!r_sync2) begin
                    w_state_nxt = w_deb_done ? IDLE : WAIT_LOW;
                    w_deb_nxt   = w_deb_done ? '0 : w_deb_inc;
                    w_level_nxt = !w_deb_done;
                end
            end
            WAIT_LOW: begin
                if (r_sync2) begin
                    w_state_nxt = PRESSED;
                    w_deb_nxt   = '0;
                end else if (w_deb_done) begin
                    w_state_nxt = IDLE;
                    w_deb_nxt   = '0;
                    w_level_nxt = 1'b0;
                end else begin
                    w_deb_nxt   = w_deb_inc;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_deb_nxt   = '0;
                w_level_nxt = 1'b0;
            end
        endcase
    end

    assign btn_level = r_level;

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] HOLD   = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - REPEAT_CYCLES);

    logic [CNT_W-1:0] r_hold_cnt, w_hold_inc;
    logic             r_repeat;

    assign w_hold_inc = r_hold_cnt + 1'b1;

    // Counts only while staying in PRESSED; frozen in WAIT_LOW, so a due pulse waits for the return.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold_cnt <= '0;
            r_repeat   <= 1'b0;
        end else begin
            r_repeat <= 1'b0;
            if (!r_level && w_level_nxt) begin
                r_hold_cnt <= '0;
            end else if (r_state == PRESSED && w_state_nxt == PRESSED) begin
                r_hold_cnt <= (w_hold_inc == HOLD) ? RELOAD : w_hold_inc;
                r_repeat   <= (w_hold_inc == HOLD);
            end
        end
    end

    assign btn_repeat = r_repeat;
`else
    assign btn_repeat = 1'b0;
`endif
endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: randomized and directed checks of button_debounce against a run-length reference model.
module tb_button_debounce;
    localparam int D = 4;
    localparam int H = 10;
    localparam int R = 3;
`ifdef BUTTON_AUTO_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_raw = 1'b0;
    logic btn_level, btn_repeat;

    int total = 0;
    int bad = 0;

    logic m_s1 = 1'b0, m_s2 = 1'b0, m_lvl = 1'b0, m_rep = 1'b0;
    int   m_run = 0, m_h = 0;

    button_debounce #(
        .CNT_W(20), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R)
    ) dut (
        .clk(clk), .reset(reset), .btn_raw(btn_raw),
        .btn_level(btn_level), .btn_repeat(btn_repeat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Level flips once D consecutive synchronised samples disagree with it.
    // Hold time counts edges spent staying pressed; pulses at H, H+R, H+2R, ...
    task automatic model_edge(input logic raw, input logic rst);
        int   prev_run;
        logic prev_lvl;
        if (rst) begin
            m_s1 = 0; m_s2 = 0; m_lvl = 0; m_run = 0; m_h = 0; m_rep = 0;
        end else begin
            prev_run = m_run;
            prev_lvl = m_lvl;
            m_rep = 0;
            if (m_s2 != m_lvl) begin
                m_run++;
                if (m_run == D) begin
                    m_lvl = ~m_lvl;
                    m_run = 0;
                    m_h = 0;
                end
            end else begin
                m_run = 0;
            end
            if (prev_lvl && m_lvl && m_s2 && prev_run == 0) begin
                m_h++;
                m_rep = REP_EN && m_h >= H && ((m_h - H) % R) == 0;
            end
            m_s2 = m_s1;
            m_s1 = raw;
        end
    endtask

    task automatic step(input logic raw, input logic rst);
        btn_raw = raw;
        reset = rst;
        @(posedge clk);
        model_edge(raw, rst);
        #1;
        check("model_level", int'(btn_level), int'(m_lvl));
        check("model_repeat", int'(btn_repeat), int'(m_rep));
    endtask

    task automatic press_latency(input string tag, input logic raw);
        for (int k = 1; k <= 6; k++) begin
            step(raw, 1'b0);
            if (k == 5) check({tag, "_edge5"}, int'(btn_level), int'(!raw));
            if (k == 6) check({tag, "_edge6"}, int'(btn_level), int'(raw));
        end
    endtask

    initial begin
        int pulses;
        int len;
        logic v;
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        check("reset_level", int'(btn_level), 0);
        check("reset_repeat", int'(btn_repeat), 0);

        press_latency("assert", 1'b1);
        pulses = 0;
        for (int j = 1; j <= 18; j++) begin
            step(1'b1, 1'b0);
            pulses += int'(btn_repeat);
        end
        for (int k = 1; k <= 6; k++) begin
            step(1'b0, 1'b0);
            pulses += int'(btn_repeat);
            if (k == 5) check("release_edge5", int'(btn_level), 1);
            if (k == 6) check("release_edge6", int'(btn_level), 0);
        end
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b0);
            pulses += int'(btn_repeat);
        end
        check("repeat_pulses", pulses, REP_EN ? 4 : 0);

        for (int k = 0; k < 4; k++) begin
            step(k[0] ? 1'b0 : 1'b1, 1'b0);
            check("bounce_hold_low", int'(btn_level), 0);
        end
        press_latency("bounce", 1'b1);

        for (int k = 0; k < 3; k++) step(1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0);
            check("glitch_hold_high", int'(btn_level), 1);
        end
        press_latency("glitch_release", 1'b0);

        for (int k = 0; k < 3; k++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        check("rst_wait_high_level", int'(btn_level), 0);
        check("rst_wait_high_repeat", int'(btn_repeat), 0);
        press_latency("after_rst1", 1'b1);
        for (int k = 0; k < 12; k++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        check("rst_pressed_level", int'(btn_level), 0);
        check("rst_pressed_repeat", int'(btn_repeat), 0);
        press_latency("after_rst2", 1'b1);
        press_latency("final_release", 1'b0);

        for (int n = 0; n < 400; n++) begin
            v = 1'($urandom_range(0, 1));
            len = (n % 5 == 0) ? int'($urandom_range(10, 30)) : int'($urandom_range(1, 6));
            for (int k = 0; k < len; k++) step(v, ($urandom_range(0, 299) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
